// File: rtl/sccb_slave_responder.sv
// SCCB slave with an internal register file: oversamples sio_c/sio_d on clk,
// accepts ID/sub-address/data writes and serves sequential reads.
module sccb_slave_responder #(
  parameter logic [6:0] SLV_ID      = 7'h21,
  parameter int         REG_DEPTH   = 256,
  parameter logic [7:0] REG_RST_VAL = 8'h00,
  parameter int         AUTO_INC    = 1,
  parameter int         ACK_EN      = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sio_c,
  input  logic       sio_d_i,
  output logic       sio_d_o,
  output logic       sio_d_oe,
  output logic       wr_vld_o,
  output logic [7:0] wr_addr_o,
  output logic [7:0] wr_data_o,
  output logic       rd_vld_o,
  output logic       err_o,
  output logic       busy_o
);

  localparam int AW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ID, S_SUB, S_WDAT, S_RDAT, S_IGNORE
  } state_t;

  state_t     r_state;
  logic       r_c_meta, r_c_sync, r_c_prev;
  logic       r_d_meta, r_d_sync, r_d_prev;
  logic [3:0] r_bit;
  logic [7:0] r_sh;
  logic [7:0] r_tx;
  logic [7:0] r_ptr;
  logic       r_rd_nack;
  logic       r_oe, r_do;
  logic       r_wr_vld, r_rd_vld, r_err, r_busy;
  logic [7:0] r_wr_addr, r_wr_data;
  logic [7:0] r_mem [REG_DEPTH];

  logic       w_c_rise, w_c_fall, w_start, w_stop;
  logic       w_in_rng, w_id_match;
  logic [7:0] w_byte, w_ptr_nxt, w_rd_byte;

  assign w_c_rise   = r_c_sync & ~r_c_prev;
  assign w_c_fall   = ~r_c_sync & r_c_prev;
  assign w_start    = r_c_sync & r_c_prev & r_d_prev & ~r_d_sync;
  assign w_stop     = r_c_sync & r_c_prev & ~r_d_prev & r_d_sync;
  assign w_byte     = {r_sh[6:0], r_d_sync};
  assign w_in_rng   = ({1'b0, r_ptr} < 9'(REG_DEPTH));
  assign w_id_match = (r_sh[7:1] == SLV_ID);
  assign w_ptr_nxt  = (AUTO_INC == 0) ? r_ptr :
                      (r_ptr == 8'(REG_DEPTH - 1)) ? 8'd0 : r_ptr + 8'd1;
  assign w_rd_byte  = w_in_rng ? r_mem[r_ptr[AW-1:0]] : 8'hFF;

  // Synchronizers idle high so reset never fabricates a start or stop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c_meta <= 1'b1; r_c_sync <= 1'b1; r_c_prev <= 1'b1;
      r_d_meta <= 1'b1; r_d_sync <= 1'b1; r_d_prev <= 1'b1;
    end else begin
      r_c_meta <= sio_c;   r_c_sync <= r_c_meta; r_c_prev <= r_c_sync;
      r_d_meta <= sio_d_i; r_d_sync <= r_d_meta; r_d_prev <= r_d_sync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_bit     <= 4'd0;
      r_sh      <= 8'h00;
      r_tx      <= 8'h00;
      r_ptr     <= 8'h00;
      r_rd_nack <= 1'b0;
      r_oe      <= 1'b0;
      r_do      <= 1'b1;
      r_wr_vld  <= 1'b0;
      r_rd_vld  <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_wr_addr <= 8'h00;
      r_wr_data <= 8'h00;
      for (int i = 0; i < REG_DEPTH; i++) r_mem[i] <= REG_RST_VAL;
    end else begin
      r_wr_vld <= 1'b0;
      r_rd_vld <= 1'b0;
      r_err    <= 1'b0;
      if (w_start) begin
        r_state   <= S_ID;
        r_bit     <= 4'd0;
        r_busy    <= 1'b1;
        r_rd_nack <= 1'b0;
        r_oe      <= 1'b0;
        r_do      <= 1'b1;
      end else if (w_stop) begin
        r_state <= S_IDLE;
        r_bit   <= 4'd0;
        r_busy  <= 1'b0;
        r_oe    <= 1'b0;
        r_do    <= 1'b1;
      end else begin
        if (w_c_rise && r_state != S_IDLE && r_state != S_IGNORE) begin
          r_bit <= (r_bit == 4'd8) ? 4'd0 : r_bit + 4'd1;
          if (r_bit != 4'd8) r_sh <= w_byte;
          case (r_state)
            S_ID: if (r_bit == 4'd8) begin
              if (!w_id_match) begin
                r_state <= S_IGNORE;
                r_err   <= 1'b1;
              end else if (r_sh[0]) begin
                r_state   <= S_RDAT;
                r_tx      <= w_rd_byte;
                r_rd_vld  <= 1'b1;
                r_rd_nack <= 1'b0;
                if (!w_in_rng) r_err <= 1'b1;
              end else begin
                r_state <= S_SUB;
              end
            end
            S_SUB: begin
              if (r_bit == 4'd7) r_ptr <= w_byte;
              if (r_bit == 4'd8) r_state <= S_WDAT;
            end
            S_WDAT: if (r_bit == 4'd7) begin
              if (w_in_rng) begin
                r_mem[r_ptr[AW-1:0]] <= w_byte;
                r_wr_vld  <= 1'b1;
                r_wr_addr <= r_ptr;
                r_wr_data <= w_byte;
              end else begin
                r_err <= 1'b1;
              end
              r_ptr <= w_ptr_nxt;
            end
            S_RDAT: begin
              if (r_bit == 4'd7) r_ptr <= w_ptr_nxt;
              // A NACK from the master ends the read burst: keep the bus
              // released so the master can still drive stop/start.
              if (r_bit == 4'd8) begin
                r_rd_nack <= r_d_sync;
                if (!r_d_sync) begin
                  r_tx     <= w_rd_byte;
                  r_rd_vld <= 1'b1;
                  if (!w_in_rng) r_err <= 1'b1;
                end
              end
            end
            default: ;
          endcase
        end
        if (w_c_fall) begin
          r_oe <= 1'b0;
          r_do <= 1'b1;
          case (r_state)
            S_RDAT: if (r_bit != 4'd8 && !r_rd_nack) begin
              r_oe <= 1'b1;
              r_do <= r_tx[3'd7 - r_bit[2:0]];
            end
            S_ID: if (ACK_EN != 0 && r_bit == 4'd8 && w_id_match) begin
              r_oe <= 1'b1;
              r_do <= 1'b0;
            end
            S_SUB, S_WDAT: if (ACK_EN != 0 && r_bit == 4'd8) begin
              r_oe <= 1'b1;
              r_do <= 1'b0;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign sio_d_o   = r_do;
  assign sio_d_oe  = r_oe;
  assign wr_vld_o  = r_wr_vld;
  assign wr_addr_o = r_wr_addr;
  assign wr_data_o = r_wr_data;
  assign rd_vld_o  = r_rd_vld;
  assign err_o     = r_err;
  assign busy_o    = r_busy;

endmodule

// File: doc/sccb_slave_responder.md
SCCB_SLAVE_RESPONDER -- requirements
Module: sccb_slave_responder

Interface
REQ-001 Parameter SLV_ID, default 7'h21: 7-bit SCCB slave ID matched against bits [7:1] of the ID byte.
REQ-002 Parameter REG_DEPTH, default 256: number of 8-bit registers, 2..256.
REQ-003 Parameter REG_RST_VAL, default 8'h00: reset value of every register.
REQ-004 Parameter AUTO_INC, default 1: 1 = sub-address increments after each data byte; 0 = sub-address is held.
REQ-005 Parameter ACK_EN, default 0: 1 = drive sio_d low during the 9th bit of write-direction phases.
REQ-006 Port clk, input, 1: the single clock; sio_c/sio_d are oversampled on it.
REQ-007 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 Port sio_c, input, 1: SCCB clock from the master.
REQ-009 Port sio_d_i, input, 1: SCCB data as seen on the bus.
REQ-010 Port sio_d_o, output, 1: value driven on the bus while sio_d_oe=1.
REQ-011 Port sio_d_oe, output, 1: slave drives sio_d when 1.
REQ-012 Port wr_vld_o, output, 1: one-cycle pulse when a register is written.
REQ-013 Port wr_addr_o, output, 8: sub-address of that write; valid with wr_vld_o.
REQ-014 Port wr_data_o, output, 8: data of that write; valid with wr_vld_o.
REQ-015 Port rd_vld_o, output, 1: one-cycle pulse when a read byte is loaded for transmission.
REQ-016 Port err_o, output, 1: one-cycle pulse on an ID mismatch or an out-of-range sub-address.
REQ-017 Port busy_o, output, 1: high from a detected start until the next stop.

Function
REQ-018 sio_c and sio_d_i SHALL each pass through a 2-flop synchronizer; all detection SHALL use the synchronized values.
REQ-019 Start SHALL be sync sio_d falling while sync sio_c is high; stop SHALL be sync sio_d rising while sync sio_c is high.
REQ-020 Bits SHALL be sampled on the sync sio_c rising edge, MSB first, with a 4-bit bit counter 0..8; bit 8 is the don't-care/X bit.
REQ-021 States SHALL be IDLE, ID, SUB, WDAT, RDAT, IGNORE.
- IDLE to ID on start.
- ID: on bit 8, go to SUB if ID byte bit 0 = 0, else RDAT; go to IGNORE on ID mismatch.
- SUB to WDAT after bit 8.
- WDAT stays in WDAT.
- RDAT stays in RDAT.
- Any state to IDLE on stop.
- Any state to ID on start (repeated start), with the bit counter cleared.
REQ-022 SUB SHALL latch the sub-address pointer at bit 7; a 2-phase write (ID, SUB, stop) SHALL only set the pointer.
REQ-023 WDAT SHALL write the byte to the register at the pointer on bit 7, and pulse wr_vld_o in the following clk cycle with wr_addr_o/wr_data_o.
REQ-024 After each WDAT or RDAT byte, the pointer SHALL advance by 1 if AUTO_INC=1, wrapping from REG_DEPTH-1 to 0.
REQ-025 If the pointer is >= REG_DEPTH: a write SHALL be dropped, a read SHALL return 8'hFF, and err_o SHALL pulse once for that byte.
REQ-026 Read data SHALL be driven as follows.
- Entering RDAT or starting a new byte: load the register at the pointer into the shift register and pulse rd_vld_o.
- On each sync sio_c falling edge for bits 0..7: set sio_d_oe=1 and sio_d_o to the next bit.
- At the sio_c falling edge starting bit 8: release, sio_d_oe=0.
REQ-027 With ACK_EN=1, the slave SHALL drive sio_d_oe=1, sio_d_o=0 from the falling edge before bit 8 to the falling edge after it, only in ID (matching), SUB and WDAT.
REQ-028 A stop or start before bit 7 of a byte SHALL discard the partial byte: no write, no pulse.
REQ-029 In IGNORE and IDLE, sio_d_oe SHALL be 0; err_o SHALL pulse once on entering IGNORE.
REQ-030 Start/stop detection SHALL override edge sampling when both occur in the same clk cycle.

Reset
REQ-031 On rst_n=0 the following SHALL take effect asynchronously.
- State = IDLE, bit counter = 0, pointer = 0.
- sio_d_oe=0, sio_d_o=1.
- wr_vld_o, rd_vld_o, err_o and busy_o = 0; wr_addr_o and wr_data_o = 0.
- All registers = REG_RST_VAL; synchronizer flops = 1.
REQ-032 Reset mid-transaction SHALL release the bus in the same cycle.
REQ-033 After reset is released, no byte SHALL be accepted until a new start.

Verification
REQ-034 Write 0x42, 0x2A, 0x3F, stop -> one wr_vld_o pulse with addr 0x2A and data 0x3F; reg[0x2A]=0x3F; sio_d_oe never 1 (ACK_EN=0).
REQ-035 Write 0x42, 0x2A, stop; then 0x43, stop -> rd_vld_o pulse; sio_d_o serializes 0,0,1,1,1,1,1,1; sio_d_oe=0 during bit 8.
REQ-036 Write 0x42, 0xFF, 0x11, 0x22, stop (AUTO_INC=1, REG_DEPTH=256) -> reg[0xFF]=0x11, reg[0x00]=0x22; two wr_vld_o pulses.
REQ-037 ID byte 0x44 -> single err_o pulse; no wr_vld_o; sio_d_oe stays 0 until the next start.
REQ-038 Stop after 4 bits of a WDAT byte -> no wr_vld_o; the register is unchanged; busy_o falls.
REQ-039 rst_n low during RDAT bit 3 -> sio_d_oe=0 immediately; all registers = REG_RST_VAL; the next byte is ignored until a start.
